// File: rtl/parity_scan_checker_if.sv
// Bundle between the parity scan checker, its memory bank, and the status logic.
// The checker is the master: it drives the memory read strobe and all status outputs.
interface parity_scan_checker_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              start;
    logic              odd_mode;
    logic              abort;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_parity;
    logic              busy;
    logic              done;
    logic              chk_valid;
    logic              chk_ok;
    logic [ADDR_W:0]   err_count;
    logic              err_flag;
    logic [ADDR_W-1:0] first_err_addr;

    modport master (
        input  start, odd_mode, abort, mem_data, mem_parity,
        output mem_rd, mem_addr, busy, done, chk_valid, chk_ok,
               err_count, err_flag, first_err_addr
    );

    modport slave (
        output start, odd_mode, abort, mem_data, mem_parity,
        input  mem_rd, mem_addr, busy, done, chk_valid, chk_ok,
               err_count, err_flag, first_err_addr
    );
endinterface

// File: rtl/parity_scan_checker.sv
// Sequentially reads every word of a latency-1 memory and checks full-word parity
// (data XOR stored bit) against a per-scan even/odd sense, accumulating error stats.
module parity_scan_checker #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    parity_scan_checker_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t            state;
    logic              mode_q;
    logic              mem_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              rd_v;
    logic [ADDR_W-1:0] addr_d;
    logic              busy_q;
    logic              done_q;
    logic              chk_valid_q;
    logic              chk_ok_q;
    logic [ADDR_W:0]   err_count_q;
    logic              err_flag_q;
    logic [ADDR_W-1:0] first_err_q;
    logic              word_ok;

    // Data is only meaningful while rd_v is high; word_ok is ignored otherwise.
    assign word_ok = ((^bus.mem_data) ^ bus.mem_parity) == mode_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            rd_v        <= 1'b0;
            addr_d      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_ok_q    <= 1'b0;
            err_count_q <= '0;
            err_flag_q  <= 1'b0;
            first_err_q <= '0;
        end else begin
            rd_v        <= mem_rd_q;
            addr_d      <= mem_addr_q;
            chk_valid_q <= rd_v;
            chk_ok_q    <= rd_v & word_ok;
            done_q      <= 1'b0;

            if (rd_v && !word_ok) begin
                err_count_q <= err_count_q + CNT_ONE;
                err_flag_q  <= 1'b1;
                if (!err_flag_q)
                    first_err_q <= addr_d;
            end

            case (state)
                IDLE: begin
                    // Pipeline is empty here, so clearing results cannot race an update.
                    if (bus.start) begin
                        state       <= SCAN;
                        mode_q      <= bus.odd_mode;
                        err_count_q <= '0;
                        err_flag_q  <= 1'b0;
                        first_err_q <= '0;
                        mem_rd_q    <= 1'b1;
                        mem_addr_q  <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                SCAN: begin
                    // The current read is already on the bus; abort only stops further ones.
                    if (bus.abort || mem_addr_q == LAST_ADDR) begin
                        mem_rd_q <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        mem_addr_q <= mem_addr_q + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd         = mem_rd_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.chk_valid      = chk_valid_q;
    assign bus.chk_ok         = chk_ok_q;
    assign bus.err_count      = err_count_q;
    assign bus.err_flag       = err_flag_q;
    assign bus.first_err_addr = first_err_q;

endmodule

// File: tb/tb_parity_scan_checker.sv
// Scoreboard bench for parity_scan_checker with ADDR_W=3, DATA_W=8 and a latency-1 memory model.
module tb_parity_scan_checker;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   rd_cnt;
    int   chk_cnt;
    int   rd_base;
    logic [7:0] mem_par;
    logic [7:0] exp_mask;
    logic       exp_q[$];

    parity_scan_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    parity_scan_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Word i holds data 8'h11*i; both nibbles match so the data has even weight and
    // correct even parity is 0. mem_par carries the stored bit (1 = corrupted).
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_data   <= {1'b0, bus.mem_addr, 1'b0, bus.mem_addr};
            bus.mem_parity <= mem_par[bus.mem_addr];
        end
    end

    always @(negedge clk) begin
        if (bus.mem_rd) begin
            check("rd_addr", 32'(bus.mem_addr), 32'(rd_cnt - rd_base));
            exp_q.push_back(exp_mask[bus.mem_addr]);
            rd_cnt++;
        end
        if (bus.chk_valid) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL chk_unexpected actual=1 required=0");
            end else begin
                check("chk_ok", 32'(bus.chk_ok), 32'(exp_q.pop_front()));
            end
        end
    end

    // Called at a negedge in IDLE; start is sampled at the following rising edge (E0).
    task automatic run_scan(input logic odd, input logic [7:0] ok_mask, input logic [7:0] par,
                            input int abort_at, input int exp_reads, input int exp_done,
                            input int exp_cnt, input logic exp_flag, input int exp_first);
        int cyc;
        int done_cyc;
        int chk_base;
        mem_par  = par;
        exp_mask = ok_mask;
        rd_base  = rd_cnt;
        chk_base = chk_cnt;
        bus.odd_mode = odd;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.odd_mode = ~odd;
        check("busy_scan", 32'(bus.busy), 32'd1);
        check("cnt_clear", 32'(bus.err_count), 32'd0);
        check("flag_clear", 32'(bus.err_flag), 32'd0);
        check("first_clear", 32'(bus.first_err_addr), 32'd0);
        cyc = 0;
        done_cyc = -1;
        while (cyc < 60) begin
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            bus.abort = (abort_at >= 0) && bus.mem_rd && (int'(bus.mem_addr) == abort_at);
            bus.start = (cyc == 1);
            @(negedge clk);
            cyc++;
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("busy_done", 32'(bus.busy), 32'd0);
        check("err_count", 32'(bus.err_count), 32'(exp_cnt));
        check("err_flag", 32'(bus.err_flag), 32'(exp_flag));
        check("first_err", 32'(bus.first_err_addr), 32'(exp_first));
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
        check("reads", 32'(rd_cnt - rd_base), 32'(exp_reads));
        check("chk_pulses", 32'(chk_cnt - chk_base), 32'(exp_reads));
        check("q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int seen_done;
        checks = 0; errors = 0; rd_cnt = 0; chk_cnt = 0; rd_base = 0;
        mem_par = '0; exp_mask = '1;
        reset = 1'b1;
        bus.start = 1'b0; bus.odd_mode = 1'b0; bus.abort = 1'b0;
        bus.mem_data = '0; bus.mem_parity = 1'b0;
        #3;
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_chk_valid", 32'(bus.chk_valid), 32'd0);
        check("rst_chk_ok", 32'(bus.chk_ok), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_err_flag", 32'(bus.err_flag), 32'd0);
        check("rst_first_err", 32'(bus.first_err_addr), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.abort = 1'b1;   // abort while idle must have no effect
        @(negedge clk);
        bus.abort = 1'b0;

        // clean even scan: 8 reads, done in cycle 9 after the first address cycle
        run_scan(1'b0, 8'hFF, 8'h00, -1, 8, 9, 0, 1'b0, 0);
        @(negedge clk);
        // same memory in odd mode: every word fails
        run_scan(1'b1, 8'h00, 8'h00, -1, 8, 9, 8, 1'b1, 0);
        @(negedge clk);
        // even mode, parity corrupted at 3 and 6
        run_scan(1'b0, 8'b1011_0111, 8'b0100_1000, -1, 8, 9, 2, 1'b1, 3);
        @(negedge clk);
        // abort while address 2 is presented; word 1 corrupted
        run_scan(1'b0, 8'b1111_1101, 8'b0000_0010, 2, 3, 4, 1, 1'b1, 1);
        @(negedge clk);

        // reset mid-scan with one error already counted
        mem_par = 8'b0000_0010; exp_mask = 8'b1111_1101; rd_base = rd_cnt;
        bus.odd_mode = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_addr", 32'(bus.mem_addr), 32'd4);
        check("mid_err_count", 32'(bus.err_count), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_chk_valid", 32'(bus.chk_valid), 32'd0);
        check("arst_err_count", 32'(bus.err_count), 32'd0);
        check("arst_err_flag", 32'(bus.err_flag), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        check("no_done_after_rst", 32'(seen_done), 32'd0);
        run_scan(1'b0, 8'hFF, 8'h00, -1, 8, 9, 0, 1'b0, 0);
        @(negedge clk);

        // back-to-back: second start in the IDLE cycle right after done
        run_scan(1'b1, 8'h00, 8'h00, -1, 8, 9, 8, 1'b1, 0);
        check("hold_flag", 32'(bus.err_flag), 32'd1);
        run_scan(1'b0, 8'b1101_1111, 8'b0010_0000, -1, 8, 9, 1, 1'b1, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
